// File: rtl/sample_iterator.sv
// sample_iterator: walks a step-aligned bounding box in raster order, emitting one sample per cycle.
// Define SAMPLE_CNT_EN to add sampleCnt_R14U, a saturating count of valid sample cycles.
module sample_iterator #(
   parameter int SIGFIG = 24,
   parameter int RADIX  = 10,
   parameter int VERTS  = 3,
   parameter int AXIS   = 3,
   parameter int COLORS = 3
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic signed [SIGFIG-1:0] tri_R13S    [VERTS][AXIS],
   input  logic        [SIGFIG-1:0] color_R13U  [COLORS],
   input  logic signed [SIGFIG-1:0] box_R13S    [2][2],
   input  logic                     validTri_R13H,
   input  logic [3:0]               subSample_RnnnnU,
   output logic                     halt_RnnnnH,
   output logic signed [SIGFIG-1:0] tri_R14S    [VERTS][AXIS],
   output logic        [SIGFIG-1:0] color_R14U  [COLORS],
   output logic signed [SIGFIG-1:0] sample_R14S [2],
   output logic                     validSamp_R14H
`ifdef SAMPLE_CNT_EN
   ,
   output logic [31:0]              sampleCnt_R14U
`endif
);

   typedef enum logic {WAIT, TEST} state_t;

   localparam logic signed [SIGFIG-1:0] ONE = SIGFIG'(1);

   state_t                   state_q, state_d;
   logic signed [SIGFIG-1:0] tri_q   [VERTS][AXIS];
   logic signed [SIGFIG-1:0] tri_d   [VERTS][AXIS];
   logic        [SIGFIG-1:0] color_q [COLORS];
   logic        [SIGFIG-1:0] color_d [COLORS];
   logic signed [SIGFIG-1:0] samp_q  [2];
   logic signed [SIGFIG-1:0] samp_d  [2];
   logic signed [SIGFIG-1:0] llx_q, llx_d, urx_q, urx_d, ury_q, ury_d;
   logic signed [SIGFIG-1:0] step_q, step_d, step_sel;
   logic                     row_end, last, halt, accept;

   // Non-one-hot modes fall back to 1x.
   always_comb begin
      case (subSample_RnnnnU)
         4'b0100: step_sel = ONE << (RADIX - 1);
         4'b0010: step_sel = ONE << (RADIX - 2);
         4'b0001: step_sel = ONE << (RADIX - 3);
         default: step_sel = ONE << RADIX;
      endcase
   end

   assign row_end = (samp_q[0] >= urx_q);
   assign last    = row_end && (samp_q[1] >= ury_q);
   assign halt    = (state_q == WAIT) || last;
   assign accept  = validTri_R13H && halt;

   always_comb begin
      state_d = state_q;
      tri_d   = tri_q;
      color_d = color_q;
      samp_d  = samp_q;
      llx_d   = llx_q;
      urx_d   = urx_q;
      ury_d   = ury_q;
      step_d  = step_q;
      if (accept) begin
         // Accept on the last sample chains straight into the next box.
         state_d   = TEST;
         tri_d     = tri_R13S;
         color_d   = color_R13U;
         samp_d[0] = box_R13S[0][0];
         samp_d[1] = box_R13S[0][1];
         llx_d     = box_R13S[0][0];
         urx_d     = box_R13S[1][0];
         ury_d     = box_R13S[1][1];
         step_d    = step_sel;
      end else if (state_q == TEST) begin
         if (last) begin
            state_d = WAIT;
         end else if (row_end) begin
            samp_d[0] = llx_q;
            samp_d[1] = samp_q[1] + step_q;
         end else begin
            samp_d[0] = samp_q[0] + step_q;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= WAIT;
         tri_q   <= '{default: '0};
         color_q <= '{default: '0};
         samp_q  <= '{default: '0};
         llx_q   <= '0;
         urx_q   <= '0;
         ury_q   <= '0;
         step_q  <= '0;
      end else begin
         state_q <= state_d;
         tri_q   <= tri_d;
         color_q <= color_d;
         samp_q  <= samp_d;
         llx_q   <= llx_d;
         urx_q   <= urx_d;
         ury_q   <= ury_d;
         step_q  <= step_d;
      end
   end

   assign halt_RnnnnH    = halt;
   assign tri_R14S       = tri_q;
   assign color_R14U     = color_q;
   assign sample_R14S    = samp_q;
   assign validSamp_R14H = (state_q == TEST);

`ifdef SAMPLE_CNT_EN
   logic [31:0] cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else if ((state_q == TEST) && (cnt_q != '1)) begin
         cnt_q <= cnt_q + 32'd1;
      end
   end

   assign sampleCnt_R14U = cnt_q;
`endif

endmodule

// File: tb/tb_sample_iterator.sv
// Self-checking bench for sample_iterator: directed vector table, hand-written
// multi-cycle sequences and randomized traffic against a queue-based raster model.
module tb_sample_iterator;

   localparam int SIGFIG = 24;
   localparam int RADIX  = 10;
   localparam int VERTS  = 3;
   localparam int AXIS   = 3;
   localparam int COLORS = 3;

   logic clk = 1'b0;
   logic rst;
   logic signed [SIGFIG-1:0] tri_in   [VERTS][AXIS];
   logic signed [SIGFIG-1:0] tri_out  [VERTS][AXIS];
   logic        [SIGFIG-1:0] col_in   [COLORS];
   logic        [SIGFIG-1:0] col_out  [COLORS];
   logic signed [SIGFIG-1:0] box_in   [2][2];
   logic signed [SIGFIG-1:0] samp_out [2];
   logic       vtri, halt, vsamp;
   logic [3:0] sub;
`ifdef SAMPLE_CNT_EN
   logic [31:0] cnt;
`endif

   sample_iterator #(.SIGFIG(SIGFIG), .RADIX(RADIX), .VERTS(VERTS), .AXIS(AXIS), .COLORS(COLORS)) dut (
      .clk(clk), .rst(rst),
      .tri_R13S(tri_in), .color_R13U(col_in), .box_R13S(box_in),
      .validTri_R13H(vtri), .subSample_RnnnnU(sub),
      .halt_RnnnnH(halt), .tri_R14S(tri_out), .color_R14U(col_out),
      .sample_R14S(samp_out), .validSamp_R14H(vsamp)
`ifdef SAMPLE_CNT_EN
      , .sampleCnt_R14U(cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {int x; int y;} pt_t;
   typedef struct {
      int llx; int lly; int urx; int ury; logic [3:0] s;
      int n; int fx; int fy; int lx; int ly;
   } vec_t;

   int n_checks = 0;
   int n_fail   = 0;

   // Model: the sample currently on the outputs plus the samples still to come.
   pt_t rest[$];
   pt_t cur;
   bit  cur_valid;
   bit  m_acc;
   longint m_cnt;
   logic signed [SIGFIG-1:0] m_tri [VERTS][AXIS];
   logic        [SIGFIG-1:0] m_col [COLORS];

   task automatic chk(input string name, input logic signed [63:0] got, input logic signed [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, got, exp);
      end
   endtask

   function automatic bit model_halt();
      return !cur_valid || (rest.size() == 0);
   endfunction

   task automatic model_reset();
      rest.delete();
      cur.x = 0; cur.y = 0; cur_valid = 0; m_acc = 0; m_cnt = 0;
      foreach (m_tri[v, a]) m_tri[v][a] = '0;
      foreach (m_col[c]) m_col[c] = '0;
   endtask

   task automatic model_build();
      int llx, lly, urx, ury, stp, x, y;
      pt_t p;
      llx = int'(box_in[0][0]); lly = int'(box_in[0][1]);
      urx = int'(box_in[1][0]); ury = int'(box_in[1][1]);
      case (sub)
         4'b0100: stp = 1 << (RADIX - 1);
         4'b0010: stp = 1 << (RADIX - 2);
         4'b0001: stp = 1 << (RADIX - 3);
         default: stp = 1 << RADIX;
      endcase
      rest.delete();
      y = lly;
      forever begin
         x = llx;
         forever begin
            p.x = x; p.y = y; rest.push_back(p);
            if (x >= urx) break;
            x += stp;
         end
         if (y >= ury) break;
         y += stp;
      end
   endtask

   task automatic model_step();
      bit h;
      h = model_halt();
      if (cur_valid) m_cnt++;
      m_acc = 0;
      if (vtri && h) begin
         m_acc = 1;
         model_build();
         cur = rest.pop_front();
         cur_valid = 1;
         m_tri = tri_in;
         m_col = col_in;
      end else if (cur_valid && rest.size() > 0) begin
         cur = rest.pop_front();
      end else begin
         cur_valid = 0;
      end
   endtask

   function automatic bit data_match();
      bit ok = 1;
      foreach (m_tri[v, a]) if (tri_out[v][a] !== m_tri[v][a]) ok = 0;
      foreach (m_col[c]) if (col_out[c] !== m_col[c]) ok = 0;
      return ok;
   endfunction

   task automatic check_outputs();
      chk("validSamp", vsamp, cur_valid);
      chk("halt", halt, model_halt());
      chk("sample_x", samp_out[0], cur.x);
      chk("sample_y", samp_out[1], cur.y);
      chk("tri_color_latch", data_match(), 1);
`ifdef SAMPLE_CNT_EN
      chk("sampleCnt", cnt, m_cnt);
`endif
   endtask

   task automatic cycle();
      @(posedge clk);
      if (rst) model_reset(); else model_step();
      #1;
      check_outputs();
   endtask

   task automatic set_tri(input int llx, input int lly, input int urx, input int ury, input logic [3:0] s);
      box_in[0][0] = SIGFIG'(llx); box_in[0][1] = SIGFIG'(lly);
      box_in[1][0] = SIGFIG'(urx); box_in[1][1] = SIGFIG'(ury);
      sub = s;
      foreach (tri_in[v, a]) tri_in[v][a] = SIGFIG'($urandom);
      foreach (col_in[c]) col_in[c] = SIGFIG'($urandom);
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int seen, budget;
      bit acc_seen, done;
      pt_t first, lastp;
      set_tri(v.llx, v.lly, v.urx, v.ury, v.s);
      vtri = 1;
      seen = 0; budget = 0; acc_seen = 0; done = 0;
      first.x = 0; first.y = 0; lastp = first;
      while (!done && budget < 200) begin
         cycle();
         budget++;
         if (m_acc) begin vtri = 0; acc_seen = 1; end
         if (vsamp === 1'b1) begin
            if (seen == 0) begin first.x = int'(samp_out[0]); first.y = int'(samp_out[1]); end
            lastp.x = int'(samp_out[0]); lastp.y = int'(samp_out[1]);
            seen++;
         end
         if (acc_seen && !cur_valid) done = 1;
      end
      vtri = 0;
      chk($sformatf("vec%0d_completed", idx), done, 1);
      chk($sformatf("vec%0d_count", idx), seen, v.n);
      chk($sformatf("vec%0d_first_x", idx), first.x, v.fx);
      chk($sformatf("vec%0d_first_y", idx), first.y, v.fy);
      chk($sformatf("vec%0d_last_x", idx), lastp.x, v.lx);
      chk($sformatf("vec%0d_last_y", idx), lastp.y, v.ly);
      repeat (2) cycle();
   endtask

   vec_t tbl[5];

   initial begin
      int run, budget, nvalid, accepted, idx, stp, llx, lly;
      bit started, ended;

      tbl[0] = '{llx: 0,     lly: 0,    urx: 2048, ury: 1024, s: 4'b1000, n: 6, fx: 0,     fy: 0,    lx: 2048, ly: 1024};
      tbl[1] = '{llx: 0,     lly: 0,    urx: 512,  ury: 512,  s: 4'b0100, n: 4, fx: 0,     fy: 0,    lx: 512,  ly: 512};
      tbl[2] = '{llx: 1024,  lly: 1024, urx: 1024, ury: 1024, s: 4'b1000, n: 1, fx: 1024,  fy: 1024, lx: 1024, ly: 1024};
      tbl[3] = '{llx: -256,  lly: 0,    urx: 256,  ury: 256,  s: 4'b0010, n: 6, fx: -256,  fy: 0,    lx: 256,  ly: 256};
      tbl[4] = '{llx: 128,   lly: 128,  urx: 384,  ury: 128,  s: 4'b0001, n: 3, fx: 128,   fy: 128,  lx: 384,  ly: 128};

      rst = 1; vtri = 0;
      set_tri(0, 0, 0, 0, 4'b1000);
      model_reset();
      @(posedge clk); @(posedge clk);
      #1;
      check_outputs();
      #1 rst = 0;
      cycle();

      foreach (tbl[i]) begin
         run_vec(tbl[i], i);
`ifdef SAMPLE_CNT_EN
         if (i == 1) chk("sampleCnt_after_1x_and_4x", cnt, 10);
`endif
      end

      // Back-to-back: second triangle presented while the first is still iterating.
      set_tri(0, 0, 2048, 1024, 4'b1000);
      vtri = 1;
      run = 0; started = 0; ended = 0; budget = 0; accepted = 0;
      while (budget < 100 && !(accepted == 2 && !cur_valid)) begin
         cycle();
         budget++;
         if (vsamp === 1'b1) begin
            started = 1;
            if (!ended) run++;
         end else if (started) begin
            ended = 1;
         end
         if (m_acc) begin
            accepted++;
            if (accepted == 1) set_tri(0, 0, 512, 512, 4'b0100);
            else vtri = 0;
         end
      end
      vtri = 0;
      chk("b2b_accepts", accepted, 2);
      chk("b2b_contiguous_samples", run, 10);
      repeat (2) cycle();

      // Reset on the third sample of the 1x box.
      set_tri(0, 0, 2048, 1024, 4'b1000);
      vtri = 1;
      nvalid = 0; budget = 0;
      while (nvalid < 3 && budget < 50) begin
         cycle();
         budget++;
         if (m_acc) vtri = 0;
         if (vsamp === 1'b1) nvalid++;
      end
      chk("rst_reached_third_sample", nvalid, 3);
      #1 rst = 1;
      model_reset();
      #1;
      check_outputs();
      #1 rst = 0;
      nvalid = 0;
      repeat (10) begin
         cycle();
         if (vsamp !== 1'b0) nvalid++;
      end
      chk("rst_residual_samples", nvalid, 0);

      // Random traffic; garbage and mode changes while busy must be ignored.
      accepted = 0; budget = 0;
      while (accepted < 40 && budget < 4000) begin
         if (model_halt()) begin
            if ($urandom_range(0, 9) < 7) begin
               idx = int'($urandom_range(0, 3));
               stp = 1 << (RADIX - idx);
               llx = (int'($urandom_range(0, 8)) - 4) * stp;
               lly = (int'($urandom_range(0, 8)) - 4) * stp;
               set_tri(llx, lly, llx + int'($urandom_range(0, 3)) * stp,
                       lly + int'($urandom_range(0, 3)) * stp, 4'b1000 >> idx);
               vtri = 1;
            end else begin
               vtri = 0;
            end
         end else begin
            set_tri(int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)),
                    int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)),
                    4'($urandom_range(0, 15)));
            vtri = 1'($urandom_range(0, 1));
         end
         cycle();
         budget++;
         if (m_acc) accepted++;
      end
      vtri = 0;
      budget = 0;
      while (cur_valid && budget < 200) begin
         cycle();
         budget++;
      end
      chk("random_accepts", accepted, 40);
      chk("random_drained", cur_valid, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
      $fatal(1);
   end

endmodule
